// File: rtl/udp_checksum_arbiter.sv
// Round-robin arbiter that lends one shared UDP checksum engine to N_REQ packet
// sources for a whole packet, then returns the result tagged with requester ID and length.
module udp_checksum_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  areset,
    // Handshakes: a word moves on a rising edge where tvalid & tready are both 1.
    // A source holds tvalid/tdata/tlast stable until accepted; tready may toggle freely.
    output logic [N_REQ-1:0]      req_i_tready,
    input  logic [N_REQ-1:0]      req_i_tvalid,
    input  logic [N_REQ-1:0]      req_i_tlast,
    input  logic [16*N_REQ-1:0]   req_i_tdata,
    input  logic                  eng_o_tready,
    output logic                  eng_o_tvalid,
    output logic                  eng_o_tlast,
    output logic [15:0]           eng_o_tdata,
    output logic                  eng_i_tready,
    input  logic                  eng_i_tvalid,
    input  logic [15:0]           eng_i_tdata,
    input  logic                  res_o_tready,
    output logic                  res_o_tvalid,
    output logic [15:0]           res_o_tdata,
    output logic [ID_W-1:0]       res_o_tid,
    output logic [LEN_W-1:0]      res_o_len,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2,
        OUTPUT   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  grant_inc;
    logic [LEN_W-1:0] count;
    logic [ID_W-1:0]  pick;
    logic             found;
    logic [ID_W:0]    sum;
    logic             eng_hs;

    // Scan from rr_ptr upward; iterating downward lets the closest valid requester win.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (sum >= (ID_W + 1)'(N_REQ)) begin
                sum = sum - (ID_W + 1)'(N_REQ);
            end
            if (req_i_tvalid[sum[ID_W-1:0]]) begin
                pick  = sum[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign grant_inc = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        eng_o_tvalid = 1'b0;
        eng_o_tlast  = 1'b0;
        eng_o_tdata  = req_i_tdata[16*grant +: 16];
        req_i_tready = '0;
        eng_i_tready = 1'b0;
        if (state == STREAM) begin
            eng_o_tvalid = req_i_tvalid[grant];
            eng_o_tlast  = req_i_tlast[grant];
            if (eng_o_tready) begin
                req_i_tready = N_REQ'(1) << grant;
            end
        end
        if (state == WAIT_RES) begin
            eng_i_tready = 1'b1;
        end
    end

    assign eng_hs = eng_o_tvalid & eng_o_tready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (found) state_next = STREAM;
            STREAM:   if (eng_hs && eng_o_tlast) state_next = WAIT_RES;
            WAIT_RES: if (eng_i_tvalid) state_next = OUTPUT;
            OUTPUT:   if (res_o_tready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rr_ptr       <= '0;
            grant        <= '0;
            count        <= '0;
            res_o_tvalid <= 1'b0;
            res_o_tdata  <= '0;
            res_o_tid    <= '0;
            res_o_len    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        count <= '0;
                    end
                end
                STREAM: begin
                    if (eng_hs) begin
                        if (count != '1) begin
                            count <= count + 1'b1;
                        end
                        if (eng_o_tlast) begin
                            rr_ptr <= grant_inc;
                        end
                    end
                end
                WAIT_RES: begin
                    if (eng_i_tvalid) begin
                        res_o_tvalid <= 1'b1;
                        res_o_tdata  <= eng_i_tdata;
                        res_o_tid    <= grant;
                        res_o_len    <= count;
                    end
                end
                OUTPUT: begin
                    if (res_o_tready) begin
                        res_o_tvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_udp_checksum_arbiter.sv
// Directed bench for udp_checksum_arbiter: queued requester sources, a behavioural
// checksum engine, and a negedge monitor checking engine words and tagged results.
module tb_udp_checksum_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          areset;
    logic [N-1:0]  req_i_tready;
    logic [N-1:0]  req_i_tvalid;
    logic [N-1:0]  req_i_tlast;
    logic [16*N-1:0] req_i_tdata;
    logic          eng_o_tready;
    logic          eng_o_tvalid;
    logic          eng_o_tlast;
    logic [15:0]   eng_o_tdata;
    logic          eng_i_tready;
    logic          eng_i_tvalid;
    logic [15:0]   eng_i_tdata;
    logic          res_o_tready;
    logic          res_o_tvalid;
    logic [15:0]   res_o_tdata;
    logic [1:0]    res_o_tid;
    logic [15:0]   res_o_len;
    logic [1:0]    dbg_state;

    logic [N-1:0]  s_req_i_tready;
    logic          s_eng_o_tvalid;
    logic          s_eng_o_tlast;
    logic [15:0]   s_eng_o_tdata;
    logic          s_eng_i_tready;
    logic          s_res_o_tvalid;
    logic [15:0]   s_res_o_tdata;
    logic [1:0]    s_res_o_tid;
    logic [1:0]    s_res_o_len;
    logic [1:0]    s_dbg_state;

    int checks   = 0;
    int failures = 0;
    int eng_hs_cnt = 0;
    bit rand_bp = 1'b0;
    int lat_max = 0;
    bit override_en = 1'b0;
    logic [15:0] override_val = 16'h0000;

    logic [16:0] src_q [N][$];
    logic [18:0] exp_eng_q[$];
    logic [33:0] exp_res_q[$];

    always #5 clk = ~clk;

    udp_checksum_arbiter #(.N_REQ(4), .ID_W(2), .LEN_W(16)) dut (
        .clk(clk), .areset(areset),
        .req_i_tready(req_i_tready), .req_i_tvalid(req_i_tvalid),
        .req_i_tlast(req_i_tlast), .req_i_tdata(req_i_tdata),
        .eng_o_tready(eng_o_tready), .eng_o_tvalid(eng_o_tvalid),
        .eng_o_tlast(eng_o_tlast), .eng_o_tdata(eng_o_tdata),
        .eng_i_tready(eng_i_tready), .eng_i_tvalid(eng_i_tvalid), .eng_i_tdata(eng_i_tdata),
        .res_o_tready(res_o_tready), .res_o_tvalid(res_o_tvalid),
        .res_o_tdata(res_o_tdata), .res_o_tid(res_o_tid), .res_o_len(res_o_len),
        .dbg_state(dbg_state)
    );

    // Narrow-counter twin sharing all inputs; only its length output differs.
    udp_checksum_arbiter #(.N_REQ(4), .ID_W(2), .LEN_W(2)) dut_sat (
        .clk(clk), .areset(areset),
        .req_i_tready(s_req_i_tready), .req_i_tvalid(req_i_tvalid),
        .req_i_tlast(req_i_tlast), .req_i_tdata(req_i_tdata),
        .eng_o_tready(eng_o_tready), .eng_o_tvalid(s_eng_o_tvalid),
        .eng_o_tlast(s_eng_o_tlast), .eng_o_tdata(s_eng_o_tdata),
        .eng_i_tready(s_eng_i_tready), .eng_i_tvalid(eng_i_tvalid), .eng_i_tdata(eng_i_tdata),
        .res_o_tready(res_o_tready), .res_o_tvalid(s_res_o_tvalid),
        .res_o_tdata(s_res_o_tdata), .res_o_tid(s_res_o_tid), .res_o_len(s_res_o_len),
        .dbg_state(s_dbg_state)
    );

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + 16'(s[16]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Packets must be pushed in the order the arbiter is expected to grant them.
    task automatic push_pkt(input int k, input int n, input logic [15:0] first,
                            input logic [15:0] step, input bit rnd);
        logic [15:0] w;
        logic [15:0] acc;
        logic        l;
        acc = 16'h0000;
        for (int i = 0; i < n; i++) begin
            w = rnd ? 16'($urandom) : first + 16'(i) * step;
            l = (i == n - 1);
            acc = ones_add(acc, w);
            src_q[k].push_back({l, w});
            exp_eng_q.push_back({2'(k), l, w});
        end
        exp_res_q.push_back({2'(k), 16'(n), override_en ? override_val : ~acc});
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_res_q.size() != 0 || exp_eng_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n < budget) ? 64'd1 : 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_res"}, {res_o_tvalid, res_o_tdata, res_o_tid, res_o_len}, 64'd0);
        chk({tag, "_rdy"}, {req_i_tready, eng_o_tvalid, eng_i_tready}, 64'd0);
        chk({tag, "_state"}, dbg_state, 64'd0);
        chk({tag, "_sat_len"}, s_res_o_len, 64'd0);
    endtask

    // Requester sources: present the queue head, pop it on an accepted handshake.
    initial begin
        logic [N-1:0] hs;
        logic         rst;
        logic [16:0]  f;
        req_i_tvalid = '0;
        req_i_tlast  = '0;
        req_i_tdata  = '0;
        forever begin
            @(posedge clk);
            hs  = req_i_tvalid & req_i_tready;
            rst = areset;
            #1;
            for (int k = 0; k < N; k++) begin
                if (rst) src_q[k].delete();
                else if (hs[k]) void'(src_q[k].pop_front());
                if (src_q[k].size() != 0) begin
                    f = src_q[k][0];
                    req_i_tvalid[k] = 1'b1;
                    req_i_tlast[k]  = f[16];
                    req_i_tdata[16*k +: 16] = f[15:0];
                end else begin
                    req_i_tvalid[k] = 1'b0;
                    req_i_tlast[k]  = 1'b0;
                end
            end
        end
    end

    // Behavioural engine: ones'-complement sum, inverted, after a random latency.
    initial begin
        logic        hs_o, hs_i, l, rst, pend;
        logic [15:0] w, acc, res_val;
        int          lat;
        eng_o_tready = 1'b1;
        eng_i_tvalid = 1'b0;
        eng_i_tdata  = 16'h0000;
        res_o_tready = 1'b1;
        acc = 16'h0000;
        res_val = 16'h0000;
        pend = 1'b0;
        lat = 0;
        forever begin
            @(posedge clk);
            hs_o = eng_o_tvalid && eng_o_tready;
            w    = eng_o_tdata;
            l    = eng_o_tlast;
            hs_i = eng_i_tvalid && eng_i_tready;
            rst  = areset;
            #1;
            if (rst) begin
                acc = 16'h0000;
                pend = 1'b0;
                eng_i_tvalid = 1'b0;
            end else begin
                if (hs_i) eng_i_tvalid = 1'b0;
                if (hs_o) begin
                    acc = ones_add(acc, w);
                    if (l) begin
                        pend = 1'b1;
                        res_val = override_en ? override_val : ~acc;
                        acc = 16'h0000;
                        lat = $urandom_range(0, lat_max);
                    end
                end
                if (pend && !eng_i_tvalid) begin
                    if (lat == 0) begin
                        eng_i_tvalid = 1'b1;
                        eng_i_tdata  = res_val;
                        pend = 1'b0;
                    end else begin
                        lat--;
                    end
                end
            end
            eng_o_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            res_o_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshakes seen here complete on the following rising edge.
    initial begin
        logic        hold;
        logic [33:0] saved;
        logic [18:0] e;
        logic [33:0] r;
        logic [3:0]  oh;
        logic [15:0] sat;
        hold = 1'b0;
        saved = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                hold = 1'b0;
            end else begin
                chk("tready_onehot", ($countones(req_i_tready) <= 1) ? 64'd1 : 64'd0, 64'd1);
                chk("eng_i_tready_excl",
                    (eng_i_tready && (eng_o_tvalid || res_o_tvalid || req_i_tready != '0)) ? 64'd1 : 64'd0,
                    64'd0);
                if (hold) chk("res_stable", {res_o_tvalid, res_o_tdata, res_o_tid, res_o_len}, {1'b1, saved});
                if (eng_o_tvalid && eng_o_tready) begin
                    if (exp_eng_q.size() == 0) begin
                        chk("eng_extra_word", {eng_o_tlast, eng_o_tdata}, 64'h1_0000_0000);
                    end else begin
                        e = exp_eng_q.pop_front();
                        oh = 4'b0001 << e[18:17];
                        chk("eng_word", {req_i_tready, eng_o_tlast, eng_o_tdata}, {oh, e[16], e[15:0]});
                        eng_hs_cnt++;
                    end
                end
                if (res_o_tvalid && res_o_tready) begin
                    if (exp_res_q.size() == 0) begin
                        chk("res_extra", {res_o_tid, res_o_len, res_o_tdata}, 64'hFFFF_FFFF_FFFF);
                    end else begin
                        r = exp_res_q.pop_front();
                        sat = (r[31:16] > 16'd3) ? 16'd3 : r[31:16];
                        chk("res_tid_len_data", {res_o_tid, res_o_len, res_o_tdata}, r);
                        chk("res_len_sat", s_res_o_len, sat);
                    end
                end
                hold  = res_o_tvalid && !res_o_tready;
                saved = {res_o_tdata, res_o_tid, res_o_len};
            end
        end
    end

    initial begin
        areset = 1'b1;
        #1;
        chk_reset("reset");
        repeat (3) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);

        // Round-robin with all four continuously valid: grants 0,1,2,3,0,1.
        for (int p = 0; p < 6; p++) push_pkt(p % 4, 2, 16'h0000, 16'h0000, 1'b1);
        wait_drain("rr_all_valid", 400);

        // Requester 0 alone, engine answers 0xBEEF.
        override_en  = 1'b1;
        override_val = 16'hBEEF;
        push_pkt(0, 3, 16'h1234, 16'h4444, 1'b0);
        wait_drain("basic_3word", 100);
        override_en = 1'b0;

        // Grant 3 wraps the pointer to 0; then 2 alone; then 3 beats 0 and 1.
        push_pkt(3, 2, 16'h0000, 16'h0000, 1'b1);
        wait_drain("grant3", 100);
        push_pkt(2, 2, 16'h0000, 16'h0000, 1'b1);
        wait_drain("wrap_grant2", 100);
        push_pkt(3, 1, 16'h0000, 16'h0000, 1'b1);
        push_pkt(0, 2, 16'h0000, 16'h0000, 1'b1);
        push_pkt(1, 3, 16'h0000, 16'h0000, 1'b1);
        wait_drain("ptr3_order", 200);

        // Random backpressure and latency over 52 packets, pointer starting at 2.
        rand_bp = 1'b1;
        lat_max = 3;
        for (int r = 0; r < 13; r++)
            for (int j = 0; j < 4; j++)
                push_pkt((2 + j) % 4, $urandom_range(1, 6), 16'h0000, 16'h0000, 1'b1);
        wait_drain("random_bp", 6000);
        rand_bp = 1'b0;
        lat_max = 0;
        repeat (2) @(negedge clk);

        // Counter saturation on the narrow twin: 5 words -> 3, 1 word -> 1.
        push_pkt(2, 5, 16'hA000, 16'h0101, 1'b0);
        wait_drain("sat_5word", 100);
        push_pkt(1, 1, 16'h7FFF, 16'h0000, 1'b0);
        wait_drain("single_word", 100);

        // Reset after 2 of 5 words from requester 2 (pointer currently 2).
        eng_hs_cnt = 0;
        push_pkt(2, 5, 16'h1111, 16'h1111, 1'b0);
        begin
            int n = 0;
            while (eng_hs_cnt < 2 && n < 100) begin
                @(posedge clk);
                #2;
                n++;
            end
            chk("midreset_wait", (n < 100) ? 64'd1 : 64'd0, 64'd1);
        end
        areset = 1'b1;
        #1;
        chk_reset("midreset");
        exp_eng_q.delete();
        exp_res_q.delete();
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        push_pkt(1, 3, 16'h0F0F, 16'h1234, 1'b0);
        push_pkt(3, 2, 16'hF00D, 16'h0001, 1'b0);
        wait_drain("post_reset", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
